// File: rtl/prefix_scan_engine.sv
// Carry-lookahead engine: Kogge-Stone prefix scan over (G,P) pairs. A result is valid log2(W)+1 cycles after accept.
// A single transaction is in flight at a time. in_ready is high only in IDLE, and the result is held in DONE until out_ready.
module prefix_scan_engine #(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  g_in,
  input  logic [W-1:0]  p_in,
  input  logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  carry,
  output logic          cout,
  output logic          p_all,
  output logic [CW-1:0] txn_count
);
  localparam int LOG = $clog2(W);
  localparam int LW  = $clog2(LOG + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   g_q, g_d, p_q, p_d;
  logic [LW-1:0]  level_q, level_d;
  logic [CW-1:0]  txn_q, txn_d;
  logic [LOG:0]   span;
  logic [W-1:0]   lo_mask, g_sh, p_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      level_q <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      level_q <= level_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    level_d = level_q;
    txn_d   = txn_q;
    span    = (LOG + 1)'(1) << level_q;
    // Bits below the span have no partner at this level; a mask of ones keeps their P unchanged.
    lo_mask = ~({W{1'b1}} << span);
    g_sh    = g_q << span;
    p_sh    = (p_q << span) | lo_mask;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d     = g_in;
          g_d[0]  = g_in[0] | (p_in[0] & cin);
          p_d     = p_in;
          level_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (level_q == LW'(LOG)) begin
          state_d = DONE;
        end else begin
          g_d     = g_q | (p_q & g_sh);
          p_d     = p_q & p_sh;
          level_d = level_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          txn_d   = txn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign carry     = g_q;
  assign cout      = g_q[W-1];
  assign p_all     = p_q[W-1];
  assign txn_count = txn_q;
endmodule

// File: tb/tb_prefix_scan_engine.sv
// Directed-table and random checks of prefix_scan_engine against a ripple-carry reference.
module tb_prefix_scan_engine;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, cin, out_valid, out_ready, cout, p_all;
  logic [W-1:0]  g_in, p_in, carry;
  logic [CW-1:0] txn_count;
  logic [CW-1:0] exp_txn;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  prefix_scan_engine #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_in(g_in), .p_in(p_in), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .carry(carry), .cout(cout), .p_all(p_all),
    .txn_count(txn_count)
  );

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         c;
    logic [W-1:0] exp_carry;
    logic         exp_cout;
    logic         exp_pall;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ripple(input logic [W-1:0] g, input logic [W-1:0] p, input logic c);
    logic [W-1:0] r;
    logic         prev;
    prev = c;
    for (int i = 0; i < W; i++) begin
      r[i] = g[i] | (p[i] & prev);
      prev = r[i];
    end
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge with inputs scrambled.
  task automatic accept(input logic [W-1:0] g, input logic [W-1:0] p, input logic c);
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    g_in = g;
    p_in = p;
    cin = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    g_in = W'($urandom);
    p_in = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_txn = exp_txn + 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_txn = '0;
  endtask

  initial begin
    int           lat;
    logic [W-1:0] g, p, exp_c;
    logic         c;

    vecs[0] = '{16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};
    vecs[1] = '{16'h0001, 16'h7FFE, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h00F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[8] = '{16'h0101, 16'hFEFE, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    g_in = '0; p_in = '0; cin = 1'b0; exp_txn = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_carry", {48'd0, carry}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_p_all", {63'd0, p_all}, 64'd0);
    chk("rst_txn", {48'd0, txn_count}, 64'd0);

    foreach (vecs[i]) begin
      accept(vecs[i].g, vecs[i].p, vecs[i].c);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("vec%0d_carry", i), {48'd0, carry}, {48'd0, vecs[i].exp_carry});
      chk($sformatf("vec%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].exp_cout});
      chk($sformatf("vec%0d_p_all", i), {63'd0, p_all}, {63'd0, vecs[i].exp_pall});
      consume();
      chk($sformatf("vec%0d_txn", i), {48'd0, txn_count}, {48'd0, exp_txn});
    end

    // Backpressure: result must hold for 10 stalled cycles; a request offered meanwhile is ignored.
    exp_c = ripple(16'h0F0F, 16'h30F0, 1'b1);
    accept(16'h0F0F, 16'h30F0, 1'b1);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd5);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      g_in = 16'h0000;
      p_in = 16'h0000;
      cin = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_carry", {48'd0, carry}, {48'd0, exp_c});
      chk("bp_p_all", {63'd0, p_all}, 64'd0);
    end
    in_valid = 1'b0;
    consume();
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_txn", {48'd0, txn_count}, {48'd0, exp_txn});

    // Reset sampled on the second edge after accept.
    pulse_reset();
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midscan_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midscan_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midscan_carry", {48'd0, carry}, 64'd0);
    chk("midscan_txn", {48'd0, txn_count}, 64'd0);

    // Reset and accept on the same edge: reset wins, nothing goes in flight.
    rst = 1'b1;
    in_valid = 1'b1;
    g_in = 16'hFFFF;
    p_in = 16'hFFFF;
    cin = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_accept_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (7) @(posedge clk);
    #1;
    chk("rst_accept_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_accept_carry", {48'd0, carry}, 64'd0);

    // Reset and out_ready on the same edge in DONE: no count.
    accept(16'h0003, 16'h0000, 1'b0);
    wait_valid(lat);
    chk("rst_done_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    exp_txn = '0;
    chk("rst_done_txn", {48'd0, txn_count}, 64'd0);
    chk("rst_done_out_valid", {63'd0, out_valid}, 64'd0);

    for (int n = 0; n < 1000; n++) begin
      g = W'($urandom) & W'($urandom);
      p = W'($urandom) | W'($urandom);
      c = 1'($urandom);
      exp_c = ripple(g, p, c);
      accept(g, p, c);
      wait_valid(lat);
      chk("rnd_latency", 64'(lat), 64'd5);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rnd_carry", {48'd0, carry}, {48'd0, exp_c});
      chk("rnd_cout", {63'd0, cout}, {63'd0, exp_c[W-1]});
      chk("rnd_p_all", {63'd0, p_all}, {63'd0, &p});
      consume();
    end
    chk("rnd_txn_final", {48'd0, txn_count}, {48'd0, exp_txn});
    chk("rnd_txn_1000", {48'd0, txn_count}, 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
